// File: rtl/lock_and_clear_if.sv
// Board-lock handshake and board-RAM port bundle between the fall sequencer/RAM side
// (master) and the lock_and_clear engine (slave).
interface lock_and_clear_if #(
  parameter int COLOUR_W = 6
) ();
  logic                start;
  logic [4:0]          X_anchor;
  logic [5:0]          Y_anchor;
  logic [7:0]          piece_x_off;
  logic [7:0]          piece_y_off;
  logic [COLOUR_W-1:0] piece_colour;
  logic [COLOUR_W-1:0] ram_Q;
  logic [7:0]          ram_addr;
  logic [COLOUR_W-1:0] ram_D;
  logic                ram_wren;
  logic                busy;
  logic                done;
  logic [2:0]          lines_cleared;
  logic                game_over;

  modport master (
    output start, X_anchor, Y_anchor, piece_x_off, piece_y_off, piece_colour, ram_Q,
    input  ram_addr, ram_D, ram_wren, busy, done, lines_cleared, game_over
  );

  modport slave (
    input  start, X_anchor, Y_anchor, piece_x_off, piece_y_off, piece_colour, ram_Q,
    output ram_addr, ram_D, ram_wren, busy, done, lines_cleared, game_over
  );
endinterface

// File: rtl/lock_and_clear.sv
// Writes a landed piece into the board RAM, then removes full rows bottom-up. Latency 269 cycles
// plus 2*WIDTH*r+WIDTH+11 per row cleared at r; start is ignored unless idle.
module lock_and_clear #(
  parameter int WIDTH       = 10,
  parameter int HEIGHT      = 24,
  parameter int COLOUR_W    = 6,
  parameter int HIDDEN_ROWS = 4
) (
  input logic             clk,
  input logic             reset,
  lock_and_clear_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOCK, SCAN, SHIFT, CLEAR_TOP, DONE} state_t;

  localparam logic [6:0] W7       = 7'(WIDTH);
  localparam logic [6:0] H7       = 7'(HEIGHT);
  localparam logic [6:0] HID7     = 7'(HIDDEN_ROWS);
  localparam logic [5:0] LAST_ROW = 6'(HEIGHT - 1);
  localparam logic [5:0] SCAN_END = 6'(WIDTH);
  localparam logic [5:0] COL_END  = 6'(WIDTH - 1);
  localparam logic [5:0] SH_END   = 6'(2 * WIDTH - 1);

  state_t              state;
  logic [5:0]          cnt;
  logic [5:0]          row;
  logic [5:0]          k;
  logic                full_acc;
  logic [4:0]          x_a;
  logic [5:0]          y_a;
  logic [7:0]          xo_a;
  logic [7:0]          yo_a;
  logic [COLOUR_W-1:0] colour_a;

  function automatic logic [7:0] rc(input logic [5:0] r, input logic [5:0] c);
    return 8'(r) * 8'(WIDTH) + 8'(c);
  endfunction

  logic       idle;
  logic [1:0] idx;
  logic [1:0] cxo;
  logic [1:0] cyo;
  logic [4:0] sel_x;
  logic [5:0] sel_y;
  logic [7:0] sel_xo;
  logic [7:0] sel_yo;
  logic [4:0] ccol;
  logic [5:0] crow;
  logic [7:0] caddr;
  logic       cok;
  logic       chid;
  logic [5:0] sh_nxt;
  logic [5:0] sh_col;
  logic [7:0] sh_addr;
  logic       scan_acc;

  // Cell 0 is decoded straight from the inputs on the accepting edge, cells 1..3 from the capture.
  always_comb begin
    idle   = (state == IDLE);
    sel_x  = idle ? bus.X_anchor    : x_a;
    sel_y  = idle ? bus.Y_anchor    : y_a;
    sel_xo = idle ? bus.piece_x_off : xo_a;
    sel_yo = idle ? bus.piece_y_off : yo_a;
    idx    = idle ? 2'd0 : cnt[1:0];
    cxo    = sel_xo[{idx, 1'b0} +: 2];
    cyo    = sel_yo[{idx, 1'b0} +: 2];
    ccol   = sel_x + {3'b000, cxo};
    crow   = sel_y + {4'b0000, cyo};
    cok    = ({2'b00, ccol} < W7) && ({1'b0, crow} < H7);
    chid   = ({1'b0, crow} < HID7);
    caddr  = rc(crow, {1'b0, ccol});
  end

  // Shift moves cells in pairs: read x, read x+1, write x, write x+1, so each read word is on
  // ram_Q exactly when it is registered into ram_D. This needs WIDTH to be even.
  always_comb begin
    sh_nxt   = cnt + 6'd1;
    sh_col   = {1'b0, sh_nxt[5:2], sh_nxt[0]};
    sh_addr  = rc(sh_nxt[1] ? k : k - 6'd1, sh_col);
    scan_acc = full_acc & ((cnt == 6'd0) | (bus.ram_Q != '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      row               <= '0;
      k                 <= '0;
      full_acc          <= 1'b0;
      x_a               <= '0;
      y_a               <= '0;
      xo_a              <= '0;
      yo_a              <= '0;
      colour_a          <= '0;
      bus.ram_addr      <= '0;
      bus.ram_D         <= '0;
      bus.ram_wren      <= 1'b0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.lines_cleared <= '0;
      bus.game_over     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          bus.ram_wren <= 1'b0;
          if (bus.start) begin
            x_a               <= bus.X_anchor;
            y_a               <= bus.Y_anchor;
            xo_a              <= bus.piece_x_off;
            yo_a              <= bus.piece_y_off;
            colour_a          <= bus.piece_colour;
            bus.busy          <= 1'b1;
            bus.lines_cleared <= '0;
            bus.ram_addr      <= caddr;
            bus.ram_D         <= bus.piece_colour;
            bus.ram_wren      <= cok;
            bus.game_over     <= bus.game_over | (cok & chid);
            cnt               <= 6'd1;
            state             <= LOCK;
          end
        end
        LOCK: begin
          if (cnt == 6'd4) begin
            bus.ram_wren <= 1'b0;
            bus.ram_addr <= rc(LAST_ROW, 6'd0);
            row          <= LAST_ROW;
            cnt          <= '0;
            full_acc     <= 1'b1;
            state        <= SCAN;
          end else begin
            bus.ram_addr  <= caddr;
            bus.ram_D     <= colour_a;
            bus.ram_wren  <= cok;
            bus.game_over <= bus.game_over | (cok & chid);
            cnt           <= cnt + 6'd1;
          end
        end
        SCAN: begin
          if (cnt != SCAN_END) begin
            cnt      <= cnt + 6'd1;
            full_acc <= scan_acc;
            if (cnt < COL_END) bus.ram_addr <= rc(row, cnt + 6'd1);
          end else if (scan_acc) begin
            if (bus.lines_cleared != 3'd7) bus.lines_cleared <= bus.lines_cleared + 3'd1;
            cnt <= '0;
            if (row == 6'd0) begin
              bus.ram_addr <= '0;
              bus.ram_D    <= '0;
              bus.ram_wren <= 1'b1;
              state        <= CLEAR_TOP;
            end else begin
              k            <= row;
              bus.ram_addr <= rc(row - 6'd1, 6'd0);
              state        <= SHIFT;
            end
          end else if (row == 6'd0) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= DONE;
          end else begin
            row          <= row - 6'd1;
            cnt          <= '0;
            full_acc     <= 1'b1;
            bus.ram_addr <= rc(row - 6'd1, 6'd0);
          end
        end
        SHIFT: begin
          if (cnt == SH_END) begin
            cnt <= '0;
            if (k == 6'd1) begin
              bus.ram_addr <= '0;
              bus.ram_D    <= '0;
              bus.ram_wren <= 1'b1;
              state        <= CLEAR_TOP;
            end else begin
              k            <= k - 6'd1;
              bus.ram_addr <= rc(k - 6'd2, 6'd0);
              bus.ram_wren <= 1'b0;
            end
          end else begin
            cnt          <= sh_nxt;
            bus.ram_addr <= sh_addr;
            bus.ram_D    <= bus.ram_Q;
            bus.ram_wren <= sh_nxt[1];
          end
        end
        CLEAR_TOP: begin
          if (cnt == COL_END) begin
            bus.ram_wren <= 1'b0;
            bus.ram_addr <= rc(row, 6'd0);
            cnt          <= '0;
            full_acc     <= 1'b1;
            state        <= SCAN;
          end else begin
            bus.ram_addr <= rc(6'd0, cnt + 6'd1);
            cnt          <= cnt + 6'd1;
          end
        end
        DONE: begin
          bus.ram_wren <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
